// File: rtl/usb_ep0_in_tx_if.sv
// Signal bundle between the EP0 IN transmitter, its response-FIFO writer and the packet TX path.
// tx_* follows valid/ready: a byte transfers on any clock where tx_val_o && tx_rdy_i; while
// tx_val_o && !tx_rdy_i the byte and tx_last_o are held unchanged. The other strobes are 1-cycle pulses.
interface usb_ep0_in_tx_if;
    logic [7:0] wr_dat_i;
    logic       wr_ena_i;
    logic       full_o;
    logic       ovf_o;
    logic       setup_i;
    logic       in_tok_i;
    logic       ack_i;
    logic       to_i;
    logic       tx_val_o;
    logic [7:0] tx_dat_o;
    logic       tx_last_o;
    logic       tx_rdy_i;
    logic       busy_o;
    logic [2:0] dbg_state_o;

    modport slave (
        input  wr_dat_i, wr_ena_i, setup_i, in_tok_i, ack_i, to_i, tx_rdy_i,
        output full_o, ovf_o, tx_val_o, tx_dat_o, tx_last_o, busy_o, dbg_state_o
    );

    modport master (
        output wr_dat_i, wr_ena_i, setup_i, in_tok_i, ack_i, to_i, tx_rdy_i,
        input  full_o, ovf_o, tx_val_o, tx_dat_o, tx_last_o, busy_o, dbg_state_o
    );
endinterface

// File: rtl/usb_ep0_in_tx.sv
// EP0 IN data-stage transmitter: owns the response FIFO, frames DATA0/DATA1 packets with CRC16,
// answers NAK when empty, and keeps bytes until the host ACKs so a lost packet is resent unchanged.
module usb_ep0_in_tx #(
    parameter int DEPTH   = 8,
    parameter int MAX_PKT = 8
) (
    input logic clk_i,
    input logic rst_i,
    usb_ep0_in_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_NAK, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT_ACK
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d, rd_spec_q, rd_spec_d;
    logic [PW-1:0]  cnt_q, cnt_d, avail, n_pkt;
    logic [15:0]    crc_q, crc_d;
    logic           tgl_q, tgl_d, ovf_q;
    logic           full, wr_acc, accept, start_tok;
    logic           tx_val, tx_last;
    logic [7:0]     tx_dat;
    logic [7:0]     mem [DEPTH];

    // Reflected CRC16 (poly 0x8005), one byte LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] dat);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ dat[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Space is only released by rd_ptr, which moves on ACK or SETUP flush.
    assign full   = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign wr_acc = bus.wr_ena_i && !full && !bus.setup_i;
    assign accept = tx_val && bus.tx_rdy_i;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_spec_d = rd_spec_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        tgl_d     = tgl_q;
        start_tok = 1'b0;
        tx_val    = 1'b0;
        tx_dat    = 8'h00;
        tx_last   = 1'b0;
        avail     = '0;
        n_pkt     = '0;

        case (state_q)
            S_IDLE: start_tok = bus.in_tok_i;
            S_NAK: begin
                tx_val  = 1'b1;
                tx_dat  = 8'h5A;
                tx_last = 1'b1;
                if (accept) state_d = S_IDLE;
            end
            S_PID: begin
                tx_val = 1'b1;
                tx_dat = tgl_q ? 8'h4B : 8'hC3;
                if (accept) state_d = S_DATA;
            end
            S_DATA: begin
                tx_val = 1'b1;
                tx_dat = mem[rd_spec_q[AW-1:0]];
                if (accept) begin
                    rd_spec_d = rd_spec_q + PW'(1);
                    crc_d     = crc16_byte(crc_q, tx_dat);
                    cnt_d     = cnt_q - PW'(1);
                    if (cnt_q == PW'(1)) state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                tx_val = 1'b1;
                tx_dat = ~crc_q[7:0];
                if (accept) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                tx_val  = 1'b1;
                tx_dat  = ~crc_q[15:8];
                tx_last = 1'b1;
                if (accept) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.ack_i) begin
                    rd_ptr_d  = rd_spec_q;
                    tgl_d     = ~tgl_q;
                    state_d   = S_IDLE;
                    start_tok = bus.in_tok_i;
                end else if (bus.to_i || bus.in_tok_i) begin
                    rd_spec_d = rd_ptr_q;
                    state_d   = S_IDLE;
                    start_tok = bus.in_tok_i;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A token counts bytes from the committed pointer as it stands after this cycle's ACK.
        if (start_tok) begin
            avail     = wr_ptr_q - rd_ptr_d;
            n_pkt     = (avail > PW'(MAX_PKT)) ? PW'(MAX_PKT) : avail;
            rd_spec_d = rd_ptr_d;
            cnt_d     = n_pkt;
            crc_d     = 16'hFFFF;
            state_d   = (n_pkt == '0) ? S_NAK : S_PID;
        end

        if (bus.setup_i) begin
            state_d   = S_IDLE;
            rd_ptr_d  = wr_ptr_q;
            rd_spec_d = wr_ptr_q;
            tgl_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_spec_q <= '0;
            cnt_q     <= '0;
            crc_q     <= 16'hFFFF;
            tgl_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_spec_q <= rd_spec_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            tgl_q     <= tgl_d;
            ovf_q     <= bus.wr_ena_i && full && !bus.setup_i;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= bus.wr_dat_i;
    end

    assign bus.full_o      = full;
    assign bus.ovf_o       = ovf_q;
    assign bus.tx_val_o    = tx_val;
    assign bus.tx_dat_o    = tx_dat;
    assign bus.tx_last_o   = tx_last;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_usb_ep0_in_tx.sv
// Bench for usb_ep0_in_tx: a packet table applied in a loop plus hand-written corner sequences;
// every transmitted byte is popped from an expected queue built from a FIFO model and a bit-serial CRC.
module tb_usb_ep0_in_tx;
    localparam int DEPTH   = 8;
    localparam int MAX_PKT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_ep0_in_tx_if bus();

    usb_ep0_in_tx #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         rdy_mode = 1;
    logic [8:0] exp_q[$];
    logic [7:0] mq[$];
    logic [8:0] held;
    logic       held_v = 1'b0;

    typedef struct {
        int         nwr;
        bit         zero;
        bit         ack;
        int         exp_n;
        logic [7:0] exp_pid;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] dat);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ dat[i];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    // Builds the expected byte stream for an n-byte packet from the head of the FIFO model.
    task automatic push_packet(input int n, input logic [7:0] pid);
        logic [15:0] crc;
        if (n == 0) begin
            exp_q.push_back({1'b1, 8'h5A});
        end else begin
            crc = 16'hFFFF;
            exp_q.push_back({1'b0, pid});
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, mq[i]});
                crc = crc_model(crc, mq[i]);
            end
            crc = ~crc;
            exp_q.push_back({1'b0, crc[7:0]});
            exp_q.push_back({1'b1, crc[15:8]});
        end
    endtask

    // Driver tasks start and end just after a rising edge.
    task automatic wr(input logic [7:0] b);
        bus.wr_dat_i = b;
        bus.wr_ena_i = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(b);
        @(posedge clk); #1;
        bus.wr_ena_i = 1'b0;
    endtask

    task automatic pulse_tok();
        bus.in_tok_i = 1'b1;
        @(posedge clk); #1;
        bus.in_tok_i = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
    endtask

    task automatic pulse_to();
        bus.to_i = 1'b1;
        @(posedge clk); #1;
        bus.to_i = 1'b0;
    endtask

    task automatic pulse_setup();
        bus.setup_i = 1'b1;
        mq.delete();
        @(posedge clk); #1;
        bus.setup_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("pkt_done_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic drop_acked(input int n);
        for (int i = 0; i < n; i++) void'(mq.pop_front());
    endtask

    initial begin
        bus.tx_rdy_i = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       bus.tx_rdy_i = 1'b0;
                1:       bus.tx_rdy_i = 1'b1;
                default: bus.tx_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: compare each accepted byte with the queue head; a stalled byte must not change.
    always @(negedge clk) begin
        if (!rst && bus.tx_val_o) begin
            if (held_v) check("hold", {bus.tx_last_o, bus.tx_dat_o}, held);
            if (bus.tx_rdy_i) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte act=%0h exp=none @%0t", {bus.tx_last_o, bus.tx_dat_o}, $time);
                end else begin
                    check("tx_byte", {bus.tx_last_o, bus.tx_dat_o}, exp_q.pop_front());
                end
            end else begin
                held_v = 1'b1;
                held   = {bus.tx_last_o, bus.tx_dat_o};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        tbl[0] = '{0,  1'b0, 1'b1, 0, 8'h5A};
        tbl[1] = '{1,  1'b1, 1'b1, 1, 8'h4B};
        tbl[2] = '{10, 1'b0, 1'b0, 8, 8'hC3};
        tbl[3] = '{0,  1'b0, 1'b0, 8, 8'hC3};
        tbl[4] = '{0,  1'b0, 1'b1, 8, 8'hC3};
        tbl[5] = '{2,  1'b0, 1'b1, 2, 8'h4B};
        tbl[6] = '{3,  1'b0, 1'b0, 3, 8'hC3};
        tbl[7] = '{5,  1'b0, 1'b1, 8, 8'hC3};
        tbl[8] = '{0,  1'b0, 1'b0, 0, 8'h5A};
        tbl[9] = '{7,  1'b0, 1'b1, 7, 8'h4B};

        bus.wr_dat_i = 8'h00;
        bus.wr_ena_i = 1'b0;
        bus.setup_i  = 1'b0;
        bus.in_tok_i = 1'b0;
        bus.ack_i    = 1'b0;
        bus.to_i     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_val", bus.tx_val_o, 0);
        check("rst_tx_dat", bus.tx_dat_o, 0);
        check("rst_tx_last", bus.tx_last_o, 0);
        check("rst_full", bus.full_o, 0);
        check("rst_ovf", bus.ovf_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_state", bus.dbg_state_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Packet table with random back-pressure.
        pulse_setup();
        rdy_mode = 2;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < tbl[r].nwr; k++) wr(tbl[r].zero ? 8'h00 : 8'($urandom_range(0, 255)));
            check("tbl_full", bus.full_o, mq.size() == DEPTH);
            push_packet(tbl[r].exp_n, tbl[r].exp_pid);
            pulse_tok();
            wait_done();
            if (tbl[r].exp_n == 0) check("tbl_nak_busy", bus.busy_o, 0);
            else                   check("tbl_wait_busy", bus.busy_o, 1);
            if (tbl[r].ack) pulse_ack();
            else            pulse_to();
            if (tbl[r].ack && tbl[r].exp_n != 0) drop_acked(tbl[r].exp_n);
            check("tbl_idle_busy", bus.busy_o, 0);
        end

        // Fill to DEPTH, overflow, then ACK frees the space.
        rdy_mode = 1;
        pulse_setup();
        for (int k = 0; k < DEPTH; k++) wr(8'($urandom_range(0, 255)));
        check("fill_full", bus.full_o, 1);
        check("fill_ovf_quiet", bus.ovf_o, 0);
        wr(8'hEE);
        check("ovf_pulse", bus.ovf_o, 1);
        @(posedge clk); #1;
        check("ovf_clear", bus.ovf_o, 0);
        push_packet(DEPTH, 8'h4B);
        pulse_tok();
        wait_done();
        pulse_ack();
        drop_acked(DEPTH);
        check("ack_full_clear", bus.full_o, 0);
        push_packet(0, 8'h00);
        pulse_tok();
        wait_done();

        // SETUP while in DATA aborts the packet and flushes the FIFO.
        pulse_setup();
        for (int k = 0; k < 4; k++) wr(8'($urandom_range(0, 255)));
        exp_q.push_back({1'b0, 8'h4B});
        exp_q.push_back({1'b0, mq[0]});
        pulse_tok();
        @(posedge clk); #1;
        pulse_setup();
        check("abort_tx_val", bus.tx_val_o, 0);
        check("abort_left", exp_q.size(), 0);
        check("abort_busy", bus.busy_o, 0);
        exp_q.delete();
        push_packet(0, 8'h00);
        pulse_tok();
        wait_done();

        // Three stalled cycles in DATA.
        for (int k = 0; k < 4; k++) wr(8'($urandom_range(0, 255)));
        push_packet(4, 8'h4B);
        pulse_tok();
        @(posedge clk); #1;
        rdy_mode = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("stall_busy", bus.busy_o, 1);
        rdy_mode = 1;
        wait_done();
        pulse_ack();
        drop_acked(4);

        // Reset in the middle of a packet.
        for (int k = 0; k < 3; k++) wr(8'($urandom_range(0, 255)));
        push_packet(3, 8'hC3);
        pulse_tok();
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_tx_val", bus.tx_val_o, 0);
        check("arst_tx_dat", bus.tx_dat_o, 0);
        check("arst_tx_last", bus.tx_last_o, 0);
        check("arst_busy", bus.busy_o, 0);
        check("arst_full", bus.full_o, 0);
        exp_q.delete();
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_packet(0, 8'h00);
        pulse_tok();
        wait_done();
        wr(8'h55);
        push_packet(1, 8'h4B);
        pulse_tok();
        wait_done();
        pulse_ack();
        drop_acked(1);
        check("end_busy", bus.busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
